// File: rtl/conv_pixel_feeder.sv
// Streams one frame from a synchronous image SRAM to the 3x3 conv engine as a tagged valid/ready stream.
// Optional build macro CONV_PAD_EN: emit a zero-bordered (IMG_H+2) x (IMG_W+2) frame instead.
module conv_pixel_feeder #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int DW      = 16,
    parameter int AW      = 10,
    parameter int MEM_LAT = 1,
    parameter int FIFO_D  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] img_base,
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_eof
);

`ifdef CONV_PAD_EN
    localparam int OUT_W = IMG_W + 2;
    localparam int OUT_H = IMG_H + 2;
`else
    localparam int OUT_W = IMG_W;
    localparam int OUT_H = IMG_H;
`endif
    localparam int RW = $clog2(OUT_H + 1);
    localparam int CLW = $clog2(OUT_W + 1);
    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW = $clog2(FIFO_D + 1);
    localparam int EW = DW + 3;
    localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_D);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t           r_state;
    logic [RW-1:0]    r_row;
    logic [CLW-1:0]   r_col;
    logic [AW-1:0]    r_next_addr;
    logic [AW-1:0]    r_addr;
    logic             r_rd_en;
    logic [2:0]       r_tag_iss;
    logic             r_busy;
    logic             r_done;
    logic [MEM_LAT-1:0] r_vpipe;
    logic [2:0]       r_tpipe [MEM_LAT];
    logic [CW-1:0]    r_inflight;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [EW-1:0]    r_mem [FIFO_D];

    logic             w_last_col;
    logic             w_last_row;
    logic [2:0]       w_tag;
    logic [CW:0]      w_used;
    logic             w_credit;
    logic             w_issue_rd;
    logic             w_issue_pad;
    logic             w_step;
    logic             w_push_rd;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic [EW-1:0]    w_push_word;

    assign w_last_col = (r_col == CLW'(OUT_W - 1));
    assign w_last_row = (r_row == RW'(OUT_H - 1));
    // Tag order inside a FIFO entry: {sof, eol, eof}.
    assign w_tag      = {(r_row == '0) && (r_col == '0), w_last_col, w_last_col && w_last_row};
    assign w_used     = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit   = (r_state == S_FETCH) && (w_used < DEPTH);

`ifdef CONV_PAD_EN
    logic w_border;
    assign w_border    = (r_row == '0) || w_last_row || (r_col == '0) || w_last_col;
    assign w_issue_rd  = w_credit && !w_border;
    // A border zero may only enter the FIFO once every earlier read has landed, keeping raster order.
    assign w_issue_pad = w_credit && w_border && (r_inflight == '0);
`else
    assign w_issue_rd  = w_credit;
    assign w_issue_pad = 1'b0;
`endif

    assign w_step      = w_issue_rd || w_issue_pad;
    assign w_push_rd   = r_vpipe[MEM_LAT-1];
    assign w_push      = w_push_rd || w_issue_pad;
    assign w_push_word = w_push_rd ? {r_tpipe[MEM_LAT-1], mem_rdata} : {w_tag, {DW{1'b0}}};
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && pix_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_next_addr <= '0;
            r_addr      <= '0;
            r_rd_en     <= 1'b0;
            r_tag_iss   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= w_issue_rd;
            if (w_issue_rd) begin
                r_addr      <= r_next_addr;
                r_next_addr <= r_next_addr + AW'(1);
                r_tag_iss   <= w_tag;
            end
            if (w_step) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CLW'(1);
                end
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_state     <= S_FETCH;
                    r_busy      <= 1'b1;
                    r_row       <= '0;
                    r_col       <= '0;
                    r_next_addr <= img_base;
                end
                S_FETCH: if (w_step && w_last_col && w_last_row) r_state <= S_DRAIN;
                S_DRAIN: if ((r_count == '0) && (r_inflight == '0)) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Valid bit and tags ride alongside the SRAM read so they line up with mem_rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vpipe    <= '0;
            r_inflight <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_tpipe[i] <= '0;
        end else begin
            r_vpipe[0] <= r_rd_en;
            r_tpipe[0] <= r_tag_iss;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_tpipe[i] <= r_tpipe[i-1];
            end
            case ({w_issue_rd, w_push_rd})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_D - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(FIFO_D - 1)) ? '0 : r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; emptiness lives in r_count, and the outputs are gated below.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_word;
    end

    assign {pix_sof, pix_eol, pix_eof, pix_data} = w_valid ? r_mem[r_rd_ptr] : '0;
    assign pix_valid = w_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_addr;

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Scoreboard bench for conv_pixel_feeder: expected pixels queued at start, checked as they transfer.
module tb_conv_pixel_feeder;
    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int DW      = 16;
    localparam int AW      = 10;
    localparam int MEM_LAT = 1;
    localparam int FIFO_D  = 4;
`ifdef CONV_PAD_EN
    localparam int OUT_W = IMG_W + 2;
    localparam int OUT_H = IMG_H + 2;
`else
    localparam int OUT_W = IMG_W;
    localparam int OUT_H = IMG_H;
`endif
    localparam int N_PIX  = OUT_W * OUT_H;
    localparam int N_RD   = IMG_W * IMG_H;
    localparam int MEM_SZ = 1 << AW;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] img_base;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;

    conv_pixel_feeder #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW), .MEM_LAT(MEM_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .img_base(img_base),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data appears MEM_LAT cycles after the read strobe.
    logic [DW-1:0] sram [MEM_SZ];
    logic [DW-1:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        if (mem_rd_en) rd_pipe[0] <= sram[mem_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW+2:0] exp_q [$];
    int            xfer_cnt, rd_cnt, done_cnt;
    int            first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc, start_cyc;
    logic [AW-1:0] first_addr;
    int            iss = 0, pops_done = 0;
    bit            pend_pop = 0, stall_prev = 0;
    logic [DW+2:0] stall_word, mon_got, mon_want;

    // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
    always @(negedge clk) begin
        if (!reset_n) begin
            iss = 0; pops_done = 0; pend_pop = 0; stall_prev = 0;
        end else begin
            mon_got = {pix_sof, pix_eol, pix_eof, pix_data};
            if (mem_rd_en) begin
                if (rd_cnt == 0) first_addr = mem_addr;
                rd_cnt++;
`ifndef CONV_PAD_EN
                // Words owed to the FIFO before this read: reads issued so far minus pixels popped so far.
                n_cmp++;
                if (iss - pops_done >= FIFO_D) begin
                    n_bad++;
                    $display("FAIL credit: read issued with %0d words owed, need < %0d", iss - pops_done, FIFO_D);
                end
`endif
                iss++;
            end
            pops_done += int'(pend_pop);
            pend_pop = pix_valid && pix_ready;
            if (stall_prev) begin
                n_cmp++;
                if (!pix_valid || mon_got !== stall_word) begin
                    n_bad++;
                    $display("FAIL stall_hold: got valid=%b word=%h, need valid=1 word=%h", pix_valid, mon_got, stall_word);
                end
            end
            stall_prev = pix_valid && !pix_ready;
            stall_word = mon_got;
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid && pix_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_pixel: got word %h with nothing expected", mon_got);
                end else begin
                    mon_want = exp_q.pop_front();
                    if (mon_got !== mon_want) begin
                        n_bad++;
                        $display("FAIL pixel[%0d] {sof,eol,eof,data}: got %h, need %h", xfer_cnt, mon_got, mon_want);
                    end
                end
                if (xfer_cnt == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfer_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [DW+2:0] exp_word(input int i, input logic [AW-1:0] base);
        int r, c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        r = i / OUT_W;
        c = i % OUT_W;
`ifdef CONV_PAD_EN
        if (r == 0 || r == OUT_H - 1 || c == 0 || c == OUT_W - 1) d = '0;
        else begin
            a = base + AW'((r - 1) * IMG_W + (c - 1));
            d = sram[a];
        end
`else
        a = base + AW'(i);
        d = sram[a];
`endif
        return {i == 0, c == OUT_W - 1, i == N_PIX - 1, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input bit clear);
        if (clear) begin
            xfer_cnt = 0; rd_cnt = 0; done_cnt = 0; first_valid_cyc = -1;
        end
        for (int i = 0; i < N_PIX; i++) exp_q.push_back(exp_word(i, base));
        img_base  = base;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit rand_ready, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
            tick();
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; pix_ready = 1'b0; img_base = '0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done, mem_rd_en, pix_valid} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl {busy,done,rd_en,valid}: got %b, need 0000", {busy, done, mem_rd_en, pix_valid});
        end
        n_cmp++;
        if ({pix_sof, pix_eol, pix_eof, pix_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_pix: got %h, need 0", {pix_sof, pix_eol, pix_eof, pix_data});
        end
        reset_n = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({busy, mem_rd_en, pix_valid, mem_addr} !== '0) begin
            n_bad++;
            $display("FAIL idle_after_reset {busy,rd_en,valid,addr}: got %h, need 0", {busy, mem_rd_en, pix_valid, mem_addr});
        end
    endtask

    task automatic test_stream();
        bit ok;
        for (int i = 0; i < MEM_SZ; i++) sram[i] = DW'(i);
        pix_ready = 1'b1;
        start_frame('0, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_start: got %b, need 1", busy);
        end
        wait_done(1, 3000, 1'b0, ok);
        repeat (4) tick();
        n_cmp++;
        if (!ok || xfer_cnt != N_PIX || done_cnt != 1 || exp_q.size() != 0 || rd_cnt != N_RD) begin
            n_bad++;
            $display("FAIL stream_frame: got done=%b xfers=%0d dones=%0d left=%0d reads=%0d, need 1 %0d 1 0 %0d",
                     ok, xfer_cnt, done_cnt, exp_q.size(), rd_cnt, N_PIX, N_RD);
        end
        // done is registered one clock after the edge that accepted the last pixel.
        n_cmp++;
        if (done_cyc != last_xfer_cyc + 2) begin
            n_bad++;
            $display("FAIL done_timing: got done at cycle %0d, need %0d", done_cyc, last_xfer_cyc + 2);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_done: got %b, need 0", busy);
        end
`ifndef CONV_PAD_EN
        n_cmp++;
        if (first_valid_cyc - (start_cyc + 1) != 2 + MEM_LAT) begin
            n_bad++;
            $display("FAIL first_latency: got %0d, need %0d", first_valid_cyc - (start_cyc + 1), 2 + MEM_LAT);
        end
        n_cmp++;
        if (last_xfer_cyc - first_xfer_cyc != N_PIX - 1) begin
            n_bad++;
            $display("FAIL throughput: got span %0d, need %0d", last_xfer_cyc - first_xfer_cyc, N_PIX - 1);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit ok;
        start_frame('0, 1'b1);
        wait_done(1, 10000, 1'b1, ok);
        repeat (3) tick();
        n_cmp++;
        if (!ok || xfer_cnt != N_PIX || done_cnt != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL backpressure_frame: got done=%b xfers=%0d dones=%0d left=%0d, need 1 %0d 1 0",
                     ok, xfer_cnt, done_cnt, exp_q.size(), N_PIX);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        start_frame(AW'(1000), 1'b1);
        wait_done(1, 3000, 1'b0, ok);
        repeat (3) tick();
        n_cmp++;
        if (first_addr !== AW'(1000)) begin
            n_bad++;
            $display("FAIL wrap_first_addr: got %0d, need 1000", first_addr);
        end
        n_cmp++;
        if (!ok || xfer_cnt != N_PIX || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_frame: got done=%b xfers=%0d left=%0d, need 1 %0d 0", ok, xfer_cnt, exp_q.size(), N_PIX);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        bit seen;
        start_frame('0, 1'b1);
        repeat (100) tick();
        img_base = AW'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 3000 && xfer_cnt < N_PIX - 4; n++) tick();
        pix_ready = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (busy !== 1'b1 || pix_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_hold {busy,valid}: got %b%b, need 11", busy, pix_valid);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        pix_ready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL drain_done: got no done within 100 cycles, need one");
        end
        // Start raised in the same cycle as done: the second frame begins back to back.
        start_frame('0, 1'b0);
        wait_done(2, 3000, 1'b0, ok);
        repeat (5) tick();
        n_cmp++;
        if (!ok || xfer_cnt != 2 * N_PIX || done_cnt != 2 || exp_q.size() != 0 || rd_cnt != 2 * N_RD) begin
            n_bad++;
            $display("FAIL back_to_back: got done=%b xfers=%0d dones=%0d left=%0d reads=%0d, need 1 %0d 2 0 %0d",
                     ok, xfer_cnt, done_cnt, exp_q.size(), rd_cnt, 2 * N_PIX, 2 * N_RD);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_frame('0, 1'b1);
        for (int n = 0; n < 3000 && xfer_cnt < 300; n++) tick();
        pix_ready = 1'b0;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, mem_rd_en, pix_valid, mem_addr} !== '0) begin
            n_bad++;
            $display("FAIL midreset_ctrl {busy,done,rd_en,valid,addr}: got %h, need 0", {busy, done, mem_rd_en, pix_valid, mem_addr});
        end
        n_cmp++;
        if ({pix_sof, pix_eol, pix_eof, pix_data} !== '0) begin
            n_bad++;
            $display("FAIL midreset_pix: got %h, need 0", {pix_sof, pix_eol, pix_eof, pix_data});
        end
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        pix_ready = 1'b1;
        tick();
        start_frame('0, 1'b1);
        wait_done(1, 3000, 1'b0, ok);
        repeat (3) tick();
        n_cmp++;
        if (!ok || xfer_cnt != N_PIX || done_cnt != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL restart_frame: got done=%b xfers=%0d dones=%0d left=%0d, need 1 %0d 1 0",
                     ok, xfer_cnt, done_cnt, exp_q.size(), N_PIX);
        end
    endtask

`ifdef CONV_PAD_EN
    task automatic test_pad();
        bit ok;
        for (int i = 0; i < MEM_SZ; i++) sram[i] = DW'(i + 1);
        start_frame('0, 1'b1);
        wait_done(1, 4000, 1'b0, ok);
        repeat (3) tick();
        n_cmp++;
        if (!ok || xfer_cnt != N_PIX || rd_cnt != N_RD || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pad_frame: got done=%b xfers=%0d reads=%0d left=%0d, need 1 %0d %0d 0",
                     ok, xfer_cnt, rd_cnt, exp_q.size(), N_PIX, N_RD);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
`ifdef CONV_PAD_EN
        test_pad();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
